// File: rtl/ama_riscv_hazard_scoreboard_if.sv
// ama_riscv_hazard_scoreboard_if: ID/EX/WB to scoreboard signal bundle.
interface ama_riscv_hazard_scoreboard_if;
  logic        issue_valid;
  logic        issue_reg_we;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used;
  logic        rs2_used;
  logic        flush_ex;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall_id;
  logic [31:0] pending;
  logic [2:0]  outstanding_cnt;
  logic        sb_err;
  modport master (
    output issue_valid, issue_reg_we, issue_long, issue_rd, rs1_id, rs2_id,
           rs1_used, rs2_used, flush_ex, wb_valid, wb_rd,
    input  stall_id, pending, outstanding_cnt, sb_err
  );
  modport slave (
    input  issue_valid, issue_reg_we, issue_long, issue_rd, rs1_id, rs2_id,
           rs1_used, rs2_used, flush_ex, wb_valid, wb_rd,
    output stall_id, pending, outstanding_cnt, sb_err
  );
endinterface

// File: rtl/ama_riscv_hazard_scoreboard.sv
// ama_riscv_hazard_scoreboard: tracks in-flight long-latency writes and stalls dependent issue in ID.
module ama_riscv_hazard_scoreboard (
  input logic clk,
  input logic rst,
  ama_riscv_hazard_scoreboard_if.slave sb
);
  logic [31:0] pend, pend_nxt, set_m, clr_m;
  logic [2:0]  cnt, cnt_nxt;
  logic        ex_long_vld;
  logic [4:0]  ex_rd;
  logic        err;
  logic        h1, h2, hw, hc, stall, long_iss, wb_ok, wb_bad, fl_ok;
  always_comb begin
    h1       = sb.rs1_used & (sb.rs1_id != 5'd0) & pend[sb.rs1_id];
    h2       = sb.rs2_used & (sb.rs2_id != 5'd0) & pend[sb.rs2_id];
    hw       = sb.issue_reg_we & (sb.issue_rd != 5'd0) & pend[sb.issue_rd];
    hc       = sb.issue_long & (cnt == 3'd4);
    stall    = sb.issue_valid & (h1 | h2 | hw | hc);
    long_iss = sb.issue_valid & ~stall & sb.issue_long & sb.issue_reg_we & (sb.issue_rd != 5'd0);
    wb_ok    = sb.wb_valid & (sb.wb_rd != 5'd0) & pend[sb.wb_rd];
    wb_bad   = sb.wb_valid & ~wb_ok;
    // a flush of an op already retired (or retiring now via WB) must not be counted twice
    fl_ok    = sb.flush_ex & ex_long_vld & pend[ex_rd] & ~(wb_ok & (sb.wb_rd == ex_rd));
    set_m    = long_iss ? (32'd1 << sb.issue_rd) : 32'd0;
    clr_m    = (wb_ok ? (32'd1 << sb.wb_rd) : 32'd0) | (fl_ok ? (32'd1 << ex_rd) : 32'd0);
    pend_nxt = ((pend & ~clr_m) | set_m) & ~32'd1;
    cnt_nxt  = cnt + {2'd0, long_iss} - {2'd0, wb_ok} - {2'd0, fl_ok};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= 32'd0;
      cnt         <= 3'd0;
      ex_long_vld <= 1'b0;
      ex_rd       <= 5'd0;
      err         <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      cnt         <= cnt_nxt;
      ex_long_vld <= long_iss;
      ex_rd       <= sb.issue_rd;
      err         <= err | wb_bad;
    end
  end
  assign sb.stall_id        = stall;
  assign sb.pending         = pend;
  assign sb.outstanding_cnt = cnt;
  assign sb.sb_err          = err;
endmodule

// File: tb/tb_ama_riscv_hazard_scoreboard.sv
// tb_ama_riscv_hazard_scoreboard: directed scenarios plus random traffic against a register-set model.
module tb_ama_riscv_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int   vecs = 0;
  int   errs = 0;
  bit   pm [32];
  bit   ex_v_m;
  int   ex_rd_m;
  bit   err_m;
  ama_riscv_hazard_scoreboard_if hif ();
  ama_riscv_hazard_scoreboard dut (.clk(clk), .rst(rst), .sb(hif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int busy();
    int n = 0;
    for (int i = 0; i < 32; i++) n += pm[i] ? 1 : 0;
    return n;
  endfunction
  function automatic logic [31:0] pm_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = pm[i];
    return v;
  endfunction
  function automatic bit exp_stall();
    int r1 = int'(hif.rs1_id), r2 = int'(hif.rs2_id), rd = int'(hif.issue_rd);
    bit s = 0;
    if (hif.rs1_used && r1 != 0 && pm[r1]) s = 1;
    if (hif.rs2_used && r2 != 0 && pm[r2]) s = 1;
    if (hif.issue_reg_we && rd != 0 && pm[rd]) s = 1;
    if (hif.issue_long && busy() == 4) s = 1;
    return hif.issue_valid && s;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) pm[i] = 0;
    ex_v_m = 0; ex_rd_m = 0; err_m = 0;
  endtask
  task automatic drive(input bit iv, we, lg, input int rd, r1, input bit u1, input int r2,
                       input bit u2, fl, wv, input int wrd);
    hif.issue_valid = iv; hif.issue_reg_we = we; hif.issue_long = lg; hif.issue_rd = 5'(rd);
    hif.rs1_id = 5'(r1); hif.rs1_used = u1; hif.rs2_id = 5'(r2); hif.rs2_used = u2;
    hif.flush_ex = fl; hif.wb_valid = wv; hif.wb_rd = 5'(wrd);
  endtask
  task automatic apply();
    #4;
    if (rst) model_reset();
    chk("stall_id", {31'd0, hif.stall_id}, {31'd0, exp_stall()});
    chk("pending", hif.pending, pm_vec());
    chk("outstanding_cnt", {29'd0, hif.outstanding_cnt}, 32'(busy()));
    chk("sb_err", {31'd0, hif.sb_err}, {31'd0, err_m});
  endtask
  task automatic tick();
    bit acc, lng, wbh, flh;
    int rd = int'(hif.issue_rd), wrd = int'(hif.wb_rd), exr = ex_rd_m;
    if (!rst) begin
      acc = hif.issue_valid && !exp_stall();
      lng = acc && hif.issue_long && hif.issue_reg_we && rd != 0;
      wbh = hif.wb_valid && wrd != 0 && pm[wrd];
      flh = hif.flush_ex && ex_v_m;
      if (hif.wb_valid && !wbh) err_m = 1;
      if (wbh) pm[wrd] = 0;
      if (flh) pm[exr] = 0;
      if (lng) pm[rd] = 1;
      ex_v_m = lng; ex_rd_m = rd;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input bit iv, we, lg, input int rd, r1, input bit u1, input int r2,
                     input bit u2, fl, wv, input int wrd);
    drive(iv, we, lg, rd, r1, u1, r2, u2, fl, wv, wrd);
    apply();
    tick();
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    model_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    chk("reset_pending", hif.pending, 32'd0);
    tick();
    rst = 1'b0;
    idle();
    // load-use
    cyc(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); apply();
    chk("load_use_stall", {31'd0, hif.stall_id}, 32'd1); tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 1, 5); apply();
    chk("load_use_wb_cycle", {31'd0, hif.stall_id}, 32'd1); tick();
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0); apply();
    chk("load_use_release", {31'd0, hif.stall_id}, 32'd0); tick();
    // capacity
    for (int r = 1; r <= 4; r++) cyc(1, 1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0); apply();
    chk("cap_cnt", {29'd0, hif.outstanding_cnt}, 32'd4);
    chk("cap_stall_5th", {31'd0, hif.stall_id}, 32'd1); tick();
    drive(1, 1, 0, 10, 11, 1, 12, 1, 0, 0, 0); apply();
    chk("cap_short_ok", {31'd0, hif.stall_id}, 32'd0); tick();
    for (int r = 1; r <= 4; r++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, r);
    // flush cancel
    cyc(1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0); apply();
    chk("flush_pending7", {31'd0, hif.pending[7]}, 32'd0);
    chk("flush_cnt", {29'd0, hif.outstanding_cnt}, 32'd0);
    chk("flush_no_stall", {31'd0, hif.stall_id}, 32'd0); tick();
    // collision: WAW holds the reissue until the old write retires
    cyc(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    idle();
    drive(1, 1, 1, 9, 0, 0, 0, 0, 0, 1, 9); apply();
    chk("coll_waw", {31'd0, hif.stall_id}, 32'd1); tick();
    cyc(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0);
    apply();
    chk("coll_pending9", {31'd0, hif.pending[9]}, 32'd1);
    chk("coll_cnt", {29'd0, hif.outstanding_cnt}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    // x0 and protocol error
    cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply();
    chk("x0_pending", hif.pending, 32'd0);
    chk("x0_cnt", {29'd0, hif.outstanding_cnt}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
    repeat (3) idle();
    chk("err_sticky", {31'd0, hif.sb_err}, 32'd1);
    rst = 1'b1; idle(); rst = 1'b0;
    chk("err_cleared", {31'd0, hif.sb_err}, 32'd0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7),
          $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7), 1'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9));
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
